// File: rtl/game_ctrl_n_if.sv
// game_ctrl_n_if
//   Bundles the game-state controller's frame/collision inputs and its
//   state/enable outputs into one port.
//   master : the game-side driver. It drives frame_tick, game_start, pause,
//            hazard_hit, in_shaded and area_cnt, and receives the
//            controller's outputs.
//   slave  : the controller. It receives the inputs above and drives state,
//            run_en, istop, respawn, lives, hit_src, game_end and game_win.
interface game_ctrl_n_if #(
    parameter int NUM_HAZARDS = 6,
    parameter int LIFE_W      = 2,
    parameter int AREA_W      = 20
);
    logic                   frame_tick;
    logic                   game_start;
    logic                   pause;
    logic [NUM_HAZARDS-1:0] hazard_hit;
    logic                   in_shaded;
    logic [AREA_W-1:0]      area_cnt;

    logic [2:0]             state;
    logic                   run_en;
    logic                   istop;
    logic                   respawn;
    logic [LIFE_W-1:0]      lives;
    logic [NUM_HAZARDS-1:0] hit_src;
    logic                   game_end;
    logic                   game_win;

    modport master (
        output frame_tick, game_start, pause, hazard_hit, in_shaded, area_cnt,
        input  state, run_en, istop, respawn, lives, hit_src, game_end, game_win
    );

    modport slave (
        input  frame_tick, game_start, pause, hazard_hit, in_shaded, area_cnt,
        output state, run_en, istop, respawn, lives, hit_src, game_end, game_win
    );
endinterface

// File: rtl/game_ctrl_n.sv
// game_ctrl_n
//   Game-state controller. It merges hazard detection, the life counter and
//   the stop logic into a single registered FSM.
//   Ports:
//     clk_65M : pixel clock; the only clock.
//     clear   : synchronous, active-high reset.
//     bus     : game_ctrl_n_if.slave. Inputs are frame_tick, game_start,
//               pause, hazard_hit, in_shaded and area_cnt. Outputs are
//               state, run_en, istop, respawn, lives, hit_src, game_end and
//               game_win. Every output is registered.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | power-up; waits for game_start
//   PLAY    | balls and player move; hits and win are evaluated
//   PAUSED  | motion halted while pause is held
//   FREEZE  | post-hit hold; counts down frame_ticks
//   RESPAWN | one-cycle pulse; movers reload their start positions
//   OVER    | no lives left; waits for game_start
//   WIN     | area target reached; waits for game_start
module game_ctrl_n #(
    parameter int NUM_HAZARDS   = 6,
    parameter int LIVES         = 3,
    parameter int LIFE_W        = 2,
    parameter int FREEZE_FRAMES = 60,
    parameter int AREA_W        = 20,
    parameter int WIN_AREA      = 589824
) (
    input  logic          clk_65M,
    input  logic          clear,
    game_ctrl_n_if.slave  bus
);

    localparam int CNT_W = $clog2(FREEZE_FRAMES + 1);

    localparam logic [LIFE_W-1:0] LIVES_C    = LIFE_W'(LIVES);
    localparam logic [CNT_W-1:0]  FREEZE_C   = CNT_W'(FREEZE_FRAMES);
    localparam logic [AREA_W-1:0] WIN_AREA_C = AREA_W'(WIN_AREA);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PLAY    = 3'd1,
        S_PAUSED  = 3'd2,
        S_FREEZE  = 3'd3,
        S_RESPAWN = 3'd4,
        S_OVER    = 3'd5,
        S_WIN     = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [LIFE_W-1:0]      lives_q, lives_d;
    logic [NUM_HAZARDS-1:0] hit_src_q, hit_src_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   respawn_q, respawn_d;
    logic                   run_en_q, istop_q, game_end_q, game_win_q;

    logic hit;
    logic win;

    // in_shaded masks every hazard source in the same cycle.
    assign hit = (|bus.hazard_hit) & ~bus.in_shaded;
    assign win = (bus.area_cnt >= WIN_AREA_C);

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        hit_src_d = hit_src_q;
        cnt_d     = cnt_q;
        respawn_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.game_start) begin
                    state_d   = S_PLAY;
                    lives_d   = LIVES_C;
                    hit_src_d = '0;
                end
            end
            S_PLAY: begin
                // Win takes priority over a hit in the same cycle, so the
                // life count is left alone.
                if (win) begin
                    state_d = S_WIN;
                end else if (hit) begin
                    state_d   = S_FREEZE;
                    lives_d   = (lives_q == '0) ? '0 : lives_q - LIFE_W'(1);
                    hit_src_d = bus.hazard_hit;
                    cnt_d     = FREEZE_C;
                end else if (bus.pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: begin
                if (!bus.pause) begin
                    state_d = S_PLAY;
                end
            end
            S_FREEZE: begin
                // The exit decision takes one extra cycle after the count
                // reaches zero. A tick in the entry cycle was seen in PLAY
                // and is not counted.
                if (cnt_q == '0) begin
                    state_d = (lives_q == '0) ? S_OVER : S_RESPAWN;
                end else if (bus.frame_tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESPAWN: begin
                state_d = S_PLAY;
            end
            S_OVER, S_WIN: begin
                if (bus.game_start) begin
                    state_d   = S_PLAY;
                    lives_d   = LIVES_C;
                    hit_src_d = '0;
                    respawn_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_RESPAWN) begin
            respawn_d = 1'b1;
        end
    end

    always_ff @(posedge clk_65M) begin
        if (clear) begin
            state_q    <= S_IDLE;
            lives_q    <= LIVES_C;
            hit_src_q  <= '0;
            cnt_q      <= '0;
            respawn_q  <= 1'b0;
            run_en_q   <= 1'b0;
            istop_q    <= 1'b0;
            game_end_q <= 1'b0;
            game_win_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            hit_src_q  <= hit_src_d;
            cnt_q      <= cnt_d;
            respawn_q  <= respawn_d;
            // Decode from the next state so the flags line up with state.
            run_en_q   <= (state_d == S_PLAY);
            istop_q    <= (state_d == S_FREEZE) || (state_d == S_OVER) ||
                          (state_d == S_WIN);
            game_end_q <= (state_d == S_OVER);
            game_win_q <= (state_d == S_WIN);
        end
    end

    assign bus.state    = state_q;
    assign bus.lives    = lives_q;
    assign bus.hit_src  = hit_src_q;
    assign bus.respawn  = respawn_q;
    assign bus.run_en   = run_en_q;
    assign bus.istop    = istop_q;
    assign bus.game_end = game_end_q;
    assign bus.game_win = game_win_q;

endmodule

// File: tb/tb_game_ctrl_n.sv
// tb_game_ctrl_n
//   Directed bench for game_ctrl_n. Instance u_a uses the default
//   parameters. Instance u_b uses NUM_HAZARDS=2, LIVES=1 and
//   FREEZE_FRAMES=1. Inputs are driven and outputs sampled 1 ns after each
//   rising edge.
module tb_game_ctrl_n;

    logic clk = 1'b0;
    logic clear;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    game_ctrl_n_if #(.NUM_HAZARDS(6), .LIFE_W(2), .AREA_W(20)) ifa ();
    game_ctrl_n_if #(.NUM_HAZARDS(2), .LIFE_W(1), .AREA_W(20)) ifb ();

    game_ctrl_n #(
        .NUM_HAZARDS(6), .LIVES(3), .LIFE_W(2), .FREEZE_FRAMES(60),
        .AREA_W(20), .WIN_AREA(589824)
    ) u_a (.clk_65M(clk), .clear(clear), .bus(ifa));

    game_ctrl_n #(
        .NUM_HAZARDS(2), .LIVES(1), .LIFE_W(1), .FREEZE_FRAMES(1),
        .AREA_W(20), .WIN_AREA(589824)
    ) u_b (.clk_65M(clk), .clear(clear), .bus(ifb));

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic freeze_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ifa.frame_tick = 1'b1;
            step(1);
            ifa.frame_tick = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset;
        n_checks++; if (ifa.state !== 3'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", ifa.state); end
        n_checks++; if (ifa.lives !== 2'd3) begin n_fail++; $display("FAIL reset_lives got=%0d exp=3", ifa.lives); end
        n_checks++; if (ifa.hit_src !== 6'd0) begin n_fail++; $display("FAIL reset_hit_src got=%b exp=000000", ifa.hit_src); end
        n_checks++; if ({ifa.run_en, ifa.istop, ifa.respawn, ifa.game_end, ifa.game_win} !== 5'b0)
            begin n_fail++; $display("FAIL reset_flags got=%b exp=00000", {ifa.run_en, ifa.istop, ifa.respawn, ifa.game_end, ifa.game_win}); end
        n_checks++; if (ifb.lives !== 1'b1) begin n_fail++; $display("FAIL reset_lives_b got=%0d exp=1", ifb.lives); end
    endtask

    task automatic test_start;
        ifa.game_start = 1'b1;
        step(1);
        ifa.game_start = 1'b0;
        n_checks++; if (ifa.state !== 3'd1) begin n_fail++; $display("FAIL start_state got=%0d exp=1", ifa.state); end
        n_checks++; if (ifa.lives !== 2'd3) begin n_fail++; $display("FAIL start_lives got=%0d exp=3", ifa.lives); end
        n_checks++; if (ifa.run_en !== 1'b1) begin n_fail++; $display("FAIL start_run_en got=%b exp=1", ifa.run_en); end
        n_checks++; if (ifa.respawn !== 1'b0) begin n_fail++; $display("FAIL start_respawn got=%b exp=0", ifa.respawn); end
    endtask

    task automatic test_hit_freeze;
        ifa.hazard_hit = 6'b000100;
        step(1);
        ifa.hazard_hit = 6'b0;
        n_checks++; if (ifa.state !== 3'd3) begin n_fail++; $display("FAIL hit_state got=%0d exp=3", ifa.state); end
        n_checks++; if (ifa.lives !== 2'd2) begin n_fail++; $display("FAIL hit_lives got=%0d exp=2", ifa.lives); end
        n_checks++; if (ifa.hit_src !== 6'b000100) begin n_fail++; $display("FAIL hit_src got=%b exp=000100", ifa.hit_src); end
        n_checks++; if ({ifa.istop, ifa.run_en} !== 2'b10) begin n_fail++; $display("FAIL hit_istop_run got=%b exp=10", {ifa.istop, ifa.run_en}); end
        freeze_ticks(59);
        n_checks++; if (ifa.state !== 3'd3) begin n_fail++; $display("FAIL freeze_59_state got=%0d exp=3", ifa.state); end
        ifa.frame_tick = 1'b1;
        step(1);
        ifa.frame_tick = 1'b0;
        n_checks++; if (ifa.state !== 3'd3) begin n_fail++; $display("FAIL freeze_60_state got=%0d exp=3", ifa.state); end
        step(1);
        n_checks++; if (ifa.state !== 3'd4) begin n_fail++; $display("FAIL respawn_state got=%0d exp=4", ifa.state); end
        n_checks++; if ({ifa.respawn, ifa.istop, ifa.run_en} !== 3'b100) begin n_fail++; $display("FAIL respawn_flags got=%b exp=100", {ifa.respawn, ifa.istop, ifa.run_en}); end
        step(1);
        n_checks++; if (ifa.state !== 3'd1) begin n_fail++; $display("FAIL after_respawn_state got=%0d exp=1", ifa.state); end
        n_checks++; if ({ifa.respawn, ifa.run_en} !== 2'b01) begin n_fail++; $display("FAIL after_respawn_flags got=%b exp=01", {ifa.respawn, ifa.run_en}); end
    endtask

    task automatic test_lives_over;
        // Second hit: hazard and pause held through the whole freeze.
        ifa.hazard_hit = 6'b010000;
        step(1);
        ifa.pause = 1'b1;
        n_checks++; if (ifa.lives !== 2'd1) begin n_fail++; $display("FAIL hit2_lives got=%0d exp=1", ifa.lives); end
        freeze_ticks(59);
        ifa.frame_tick = 1'b1;
        step(1);
        ifa.frame_tick = 1'b0;
        step(1);
        n_checks++; if (ifa.state !== 3'd4) begin n_fail++; $display("FAIL hit2_pause_respawn got=%0d exp=4", ifa.state); end
        n_checks++; if (ifa.lives !== 2'd1) begin n_fail++; $display("FAIL hit2_held_lives got=%0d exp=1", ifa.lives); end
        ifa.hazard_hit = 6'b0;
        ifa.pause = 1'b0;
        step(1);
        n_checks++; if (ifa.state !== 3'd1) begin n_fail++; $display("FAIL hit2_back_play got=%0d exp=1", ifa.state); end
        // Third hit, held until game over.
        ifa.hazard_hit = 6'b100000;
        step(1);
        n_checks++; if ({ifa.lives, ifa.hit_src} !== {2'd0, 6'b100000}) begin n_fail++; $display("FAIL hit3_lives_src got=%0d/%b exp=0/100000", ifa.lives, ifa.hit_src); end
        freeze_ticks(59);
        ifa.frame_tick = 1'b1;
        step(1);
        ifa.frame_tick = 1'b0;
        step(1);
        n_checks++; if (ifa.state !== 3'd5) begin n_fail++; $display("FAIL over_state got=%0d exp=5", ifa.state); end
        n_checks++; if ({ifa.game_end, ifa.istop, ifa.run_en} !== 3'b110) begin n_fail++; $display("FAIL over_flags got=%b exp=110", {ifa.game_end, ifa.istop, ifa.run_en}); end
        step(1);
        n_checks++; if ({ifa.state, ifa.lives} !== {3'd5, 2'd0}) begin n_fail++; $display("FAIL over_hold got=%0d/%0d exp=5/0", ifa.state, ifa.lives); end
        ifa.hazard_hit = 6'b0;
        ifa.game_start = 1'b1;
        step(1);
        ifa.game_start = 1'b0;
        n_checks++; if ({ifa.state, ifa.lives} !== {3'd1, 2'd3}) begin n_fail++; $display("FAIL restart_state_lives got=%0d/%0d exp=1/3", ifa.state, ifa.lives); end
        n_checks++; if ({ifa.respawn, ifa.game_end, ifa.hit_src} !== {1'b1, 1'b0, 6'b0}) begin n_fail++; $display("FAIL restart_flags got=%b/%b/%b exp=1/0/000000", ifa.respawn, ifa.game_end, ifa.hit_src); end
        step(1);
        n_checks++; if (ifa.respawn !== 1'b0) begin n_fail++; $display("FAIL restart_respawn_pulse got=%b exp=0", ifa.respawn); end
    endtask

    task automatic test_mask_win;
        ifa.in_shaded = 1'b1;
        ifa.hazard_hit = 6'b111111;
        step(2);
        n_checks++; if ({ifa.state, ifa.lives} !== {3'd1, 2'd3}) begin n_fail++; $display("FAIL shaded_mask got=%0d/%0d exp=1/3", ifa.state, ifa.lives); end
        ifa.in_shaded = 1'b0;
        ifa.hazard_hit = 6'b0;
        ifa.area_cnt = 20'd589823;
        step(1);
        n_checks++; if (ifa.state !== 3'd1) begin n_fail++; $display("FAIL area_below_win got=%0d exp=1", ifa.state); end
        ifa.area_cnt = 20'd589824;
        ifa.hazard_hit = 6'b000001;
        step(1);
        ifa.hazard_hit = 6'b0;
        ifa.area_cnt = 20'd0;
        n_checks++; if ({ifa.state, ifa.lives} !== {3'd6, 2'd3}) begin n_fail++; $display("FAIL win_hit_state_lives got=%0d/%0d exp=6/3", ifa.state, ifa.lives); end
        n_checks++; if ({ifa.game_win, ifa.istop, ifa.run_en} !== 3'b110) begin n_fail++; $display("FAIL win_flags got=%b exp=110", {ifa.game_win, ifa.istop, ifa.run_en}); end
        ifa.game_start = 1'b1;
        step(1);
        ifa.game_start = 1'b0;
        n_checks++; if ({ifa.state, ifa.respawn, ifa.game_win} !== {3'd1, 1'b1, 1'b0}) begin n_fail++; $display("FAIL win_restart got=%0d/%b/%b exp=1/1/0", ifa.state, ifa.respawn, ifa.game_win); end
    endtask

    task automatic test_pause;
        ifa.pause = 1'b1;
        step(1);
        n_checks++; if ({ifa.state, ifa.run_en} !== {3'd2, 1'b0}) begin n_fail++; $display("FAIL pause_enter got=%0d/%b exp=2/0", ifa.state, ifa.run_en); end
        ifa.hazard_hit = 6'b001000;
        ifa.area_cnt = 20'd600000;
        step(2);
        n_checks++; if ({ifa.state, ifa.lives} !== {3'd2, 2'd3}) begin n_fail++; $display("FAIL pause_ignore got=%0d/%0d exp=2/3", ifa.state, ifa.lives); end
        ifa.hazard_hit = 6'b0;
        ifa.area_cnt = 20'd0;
        ifa.pause = 1'b0;
        step(1);
        n_checks++; if ({ifa.state, ifa.run_en} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL pause_exit got=%0d/%b exp=1/1", ifa.state, ifa.run_en); end
        ifa.game_start = 1'b1;
        step(1);
        ifa.game_start = 1'b0;
        n_checks++; if ({ifa.state, ifa.respawn, ifa.lives} !== {3'd1, 1'b0, 2'd3}) begin n_fail++; $display("FAIL start_in_play got=%0d/%b/%0d exp=1/0/3", ifa.state, ifa.respawn, ifa.lives); end
    endtask

    task automatic test_clear_mid_freeze;
        ifa.hazard_hit = 6'b000010;
        step(1);
        ifa.hazard_hit = 6'b0;
        freeze_ticks(30);
        n_checks++; if ({ifa.state, ifa.lives} !== {3'd3, 2'd2}) begin n_fail++; $display("FAIL pre_clear got=%0d/%0d exp=3/2", ifa.state, ifa.lives); end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        n_checks++; if ({ifa.state, ifa.lives, ifa.hit_src} !== {3'd0, 2'd3, 6'b0}) begin n_fail++; $display("FAIL clear_state got=%0d/%0d/%b exp=0/3/000000", ifa.state, ifa.lives, ifa.hit_src); end
        n_checks++; if ({ifa.run_en, ifa.istop, ifa.respawn, ifa.game_end, ifa.game_win} !== 5'b0)
            begin n_fail++; $display("FAIL clear_flags got=%b exp=00000", {ifa.run_en, ifa.istop, ifa.respawn, ifa.game_end, ifa.game_win}); end
        step(3);
        n_checks++; if (ifa.state !== 3'd0) begin n_fail++; $display("FAIL clear_stays_idle got=%0d exp=0", ifa.state); end
    endtask

    task automatic test_small_params;
        ifb.game_start = 1'b1;
        step(1);
        ifb.game_start = 1'b0;
        n_checks++; if ({ifb.state, ifb.lives} !== {3'd1, 1'b1}) begin n_fail++; $display("FAIL b_start got=%0d/%0d exp=1/1", ifb.state, ifb.lives); end
        // A tick coincident with the hit must not count toward the freeze.
        ifb.hazard_hit = 2'b10;
        ifb.frame_tick = 1'b1;
        step(1);
        ifb.hazard_hit = 2'b00;
        ifb.frame_tick = 1'b0;
        n_checks++; if ({ifb.state, ifb.lives, ifb.hit_src} !== {3'd3, 1'b0, 2'b10}) begin n_fail++; $display("FAIL b_hit got=%0d/%0d/%b exp=3/0/10", ifb.state, ifb.lives, ifb.hit_src); end
        step(1);
        n_checks++; if (ifb.state !== 3'd3) begin n_fail++; $display("FAIL b_entry_tick_ignored got=%0d exp=3", ifb.state); end
        ifb.frame_tick = 1'b1;
        step(1);
        ifb.frame_tick = 1'b0;
        n_checks++; if (ifb.state !== 3'd3) begin n_fail++; $display("FAIL b_after_tick got=%0d exp=3", ifb.state); end
        step(1);
        n_checks++; if ({ifb.state, ifb.game_end, ifb.istop} !== {3'd5, 1'b1, 1'b1}) begin n_fail++; $display("FAIL b_over got=%0d/%b/%b exp=5/1/1", ifb.state, ifb.game_end, ifb.istop); end
    endtask

    initial begin
        clear = 1'b1;
        ifa.frame_tick = 1'b0; ifa.game_start = 1'b0; ifa.pause = 1'b0;
        ifa.hazard_hit = '0;   ifa.in_shaded = 1'b0;  ifa.area_cnt = '0;
        ifb.frame_tick = 1'b0; ifb.game_start = 1'b0; ifb.pause = 1'b0;
        ifb.hazard_hit = '0;   ifb.in_shaded = 1'b0;  ifb.area_cnt = '0;
        step(2);
        clear = 1'b0;
        step(1);
        test_reset();
        test_start();
        test_hit_freeze();
        test_lives_over();
        test_mask_win();
        test_pause();
        test_clear_mid_freeze();
        test_small_params();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
